mpc_div_seq_35s_14ns_21: RTL and testbench

//  Sequential signed/unsigned divider, the inverse of the MPC 21s x 14ns -> 35 multiplier:

---
 rtl/mpc_div_seq_35s_14ns_21.sv | 154 +++++++++++++++
 tb/tb_mpc_div_seq_35s_14ns_21.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/mpc_div_seq_35s_14ns_21.sv
// Sequential restoring divider: signed dividend / unsigned divisor -> saturated signed quotient.
// One quotient bit per enabled cycle; start/done handshake; done lags the DONE state by one edge.
module mpc_div_seq_35s_14ns_21 #(
    parameter int ID         = 1,
    parameter int din0_WIDTH = 35,
    parameter int din1_WIDTH = 14,
    parameter int dout_WIDTH = 21
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ce,
    input  logic                  start,
    input  logic [din0_WIDTH-1:0] din0,
    input  logic [din1_WIDTH-1:0] din1,
    output logic                  busy,
    output logic                  done,
    output logic [dout_WIDTH-1:0] dout,
    output logic [din1_WIDTH:0]   rem,
    output logic                  ovf,
    output logic                  dbz
);

    localparam int CW = $clog2(din0_WIDTH) + 1;
    localparam logic [CW-1:0] CLOAD = CW'(din0_WIDTH - 1 + ID * 0);
    localparam logic [CW-1:0] CONE = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [din0_WIDTH-1:0] ONE0 = {{(din0_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [din1_WIDTH:0] ONE1 = {{din1_WIDTH{1'b0}}, 1'b1};
    localparam logic [din0_WIDTH-1:0] QPOS =
        {{(din0_WIDTH-dout_WIDTH+1){1'b0}}, {(dout_WIDTH-1){1'b1}}};
    localparam logic [din0_WIDTH-1:0] QNEG = QPOS + ONE0;
    localparam logic [dout_WIDTH-1:0] DMAX = {1'b0, {(dout_WIDTH-1){1'b1}}};
    localparam logic [dout_WIDTH-1:0] DMIN = {1'b1, {(dout_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

    state_t state, state_nx;
    logic [CW-1:0]         cnt;
    logic [din0_WIDTH-1:0] mq;
    logic [din1_WIDTH-1:0] pr;
    logic [din1_WIDTH-1:0] dv;
    logic                  neg;
    logic                  zdiv;
    logic                  accept;

    logic [din1_WIDTH:0]   sh;
    logic [din1_WIDTH:0]   diff;
    logic                  ge;
    logic [din0_WIDTH-1:0] mag;
    logic [din0_WIDTH-1:0] qn;

    logic                  busy_nx;
    logic                  done_nx;
    logic [dout_WIDTH-1:0] dout_fx;
    logic [din1_WIDTH:0]   rem_fx;
    logic                  ovf_fx;

    // busy still covers the done cycle, so a start there is refused
    assign accept = (state == S_IDLE) && start && !busy;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else if (ce) begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE: if (accept) state_nx = S_CALC;
            S_CALC: if (cnt == '0) state_nx = S_FIX;
            S_FIX:  state_nx = S_DONE;
            S_DONE: state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        busy_nx = (state_nx != S_IDLE) || (state == S_DONE);
        done_nx = (state == S_DONE);
        qn      = ~mq + ONE0;
        dout_fx = mq[dout_WIDTH-1:0];
        rem_fx  = {1'b0, pr};
        ovf_fx  = 1'b0;
        if (zdiv) begin
            dout_fx = neg ? DMIN : DMAX;
            rem_fx  = '0;
            ovf_fx  = 1'b1;
        end else if (neg) begin
            rem_fx = ~{1'b0, pr} + ONE1;
            if (mq > QNEG) begin
                dout_fx = DMIN;
                ovf_fx  = 1'b1;
            end else begin
                dout_fx = qn[dout_WIDTH-1:0];
            end
        end else if (mq > QPOS) begin
            dout_fx = DMAX;
            ovf_fx  = 1'b1;
        end
    end

    assign sh   = {pr, mq[din0_WIDTH-1]};
    assign ge   = sh >= {1'b0, dv};
    assign diff = sh - {1'b0, dv};
    assign mag  = din0[din0_WIDTH-1] ? (~din0 + ONE0) : din0;

    // mq shifts dividend magnitude out of the top while quotient bits enter at the bottom
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt  <= '0;
            mq   <= '0;
            pr   <= '0;
            dv   <= '0;
            neg  <= 1'b0;
            zdiv <= 1'b0;
            busy <= 1'b0;
            done <= 1'b0;
            dout <= '0;
            rem  <= '0;
            ovf  <= 1'b0;
            dbz  <= 1'b0;
        end else if (ce) begin
            busy <= busy_nx;
            done <= done_nx;
            unique case (state)
                S_IDLE: begin
                    if (accept) begin
                        mq   <= mag;
                        pr   <= '0;
                        dv   <= din1;
                        neg  <= din0[din0_WIDTH-1];
                        zdiv <= (din1 == '0);
                        cnt  <= CLOAD;
                    end
                end
                S_CALC: begin
                    pr  <= ge ? diff[din1_WIDTH-1:0] : sh[din1_WIDTH-1:0];
                    mq  <= {mq[din0_WIDTH-2:0], ge};
                    cnt <= cnt - CONE;
                end
                S_FIX: begin
                    dout <= dout_fx;
                    rem  <= rem_fx;
                    ovf  <= ovf_fx;
                    dbz  <= zdiv;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mpc_div_seq_35s_14ns_21.sv
// Bench for mpc_div_seq_35s_14ns_21: directed table, handshake corners and
// random operands against a plain-arithmetic reference model.
module tb_mpc_div_seq_35s_14ns_21;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        ce = 1'b1;
    logic        start = 1'b0;
    logic [34:0] din0 = '0;
    logic [13:0] din1 = '0;
    logic        busy, done, ovf, dbz;
    logic [20:0] dout;
    logic [14:0] rem;

    int checks = 0;
    int failures = 0;

    mpc_div_seq_35s_14ns_21 dut (
        .clk(clk), .reset(reset), .ce(ce), .start(start),
        .din0(din0), .din1(din1), .busy(busy), .done(done),
        .dout(dout), .rem(rem), .ovf(ovf), .dbz(dbz)
    );

    always #5 clk = ~clk;

    typedef struct {
        longint a;
        longint b;
        longint q;
        longint r;
        bit     o;
        bit     z;
    } vec_t;

    task automatic chk(input string nm, input longint got, input longint exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, got, exp);
        end
    endtask

    function automatic void model(input longint a, input longint b,
                                  output longint q, output longint r,
                                  output bit o, output bit z);
        z = (b == 0);
        o = 1'b0;
        if (z) begin
            o = 1'b1;
            r = 0;
            q = (a < 0) ? -1048576 : 1048575;
        end else begin
            q = a / b;
            r = a % b;
            if (q > 1048575) begin q = 1048575; o = 1'b1; end
            if (q < -1048576) begin q = -1048576; o = 1'b1; end
        end
    endfunction

    // Launch one division; returns edges from accept to the done cycle.
    task automatic run_div(input longint a, input longint b,
                           input int gap_at, input int gaps,
                           input bit poke, output int lat);
        logic [34:0] ta;
        int left;
        left = gaps;
        @(posedge clk); #1;
        ta = 35'(a);
        din0 = ta;
        din1 = 14'(b);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        din0 = {$urandom, $urandom};
        din1 = 14'($urandom);
        lat = 0;
        forever begin
            if (lat >= gap_at && left > 0) begin
                ce = 1'b0;
                left--;
            end else begin
                ce = 1'b1;
            end
            start = poke && (lat == 10);
            @(posedge clk); #1;
            lat++;
            if (done) break;
            if (lat > 150) begin
                chk("timeout", lat, 37 + gaps);
                break;
            end
        end
        ce = 1'b1;
        start = 1'b0;
    endtask

    task automatic check_res(input string nm, input longint a, input longint b);
        longint q, r;
        bit o, z;
        model(a, b, q, r, o, z);
        chk({nm, ".dout"}, longint'($signed(dout)), q);
        chk({nm, ".rem"}, longint'($signed(rem)), r);
        chk({nm, ".ovf"}, longint'(ovf), longint'(o));
        chk({nm, ".dbz"}, longint'(dbz), longint'(z));
    endtask

    initial begin
        vec_t vt[12];
        int lat;
        int npulse;
        longint a, b;
        logic [34:0] t35;

        vt[0]  = '{1000, 7, 142, 6, 0, 0};
        vt[1]  = '{-1000, 7, -142, -6, 0, 0};
        vt[2]  = '{-64'sd17179869184, 16383, -1048576, -64, 1, 0};
        vt[3]  = '{64'sd1073741824, 1, 1048575, 0, 1, 0};
        vt[4]  = '{-1048576, 1, -1048576, 0, 0, 0};
        vt[5]  = '{-5, 0, -1048576, 0, 1, 1};
        vt[6]  = '{5, 0, 1048575, 0, 1, 1};
        vt[7]  = '{0, 123, 0, 0, 0, 0};
        vt[8]  = '{64'sd17179869183, 16383, 1048575, 63, 1, 0};
        vt[9]  = '{1048575, 1, 1048575, 0, 0, 0};
        vt[10] = '{-1048577, 1, -1048576, 0, 1, 0};
        vt[11] = '{0, 0, 1048575, 0, 1, 1};

        #12;
        chk("rst.busy", longint'(busy), 0);
        chk("rst.done", longint'(done), 0);
        chk("rst.dout", longint'(dout), 0);
        chk("rst.rem", longint'(rem), 0);
        chk("rst.flags", longint'({ovf, dbz}), 0);
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 12; i++) begin
            run_div(vt[i].a, vt[i].b, 0, 0, 1'b0, lat);
            chk($sformatf("vec%0d.lat", i), lat, 37);
            chk($sformatf("vec%0d.busy", i), longint'(busy), 1);
            chk($sformatf("vec%0d.dout", i), longint'($signed(dout)), vt[i].q);
            chk($sformatf("vec%0d.rem", i), longint'($signed(rem)), vt[i].r);
            chk($sformatf("vec%0d.ovf", i), longint'(ovf), longint'(vt[i].o));
            chk($sformatf("vec%0d.dbz", i), longint'(dbz), longint'(vt[i].z));
            @(posedge clk); #1;
            chk($sformatf("vec%0d.pulse", i), longint'({busy, done}), 0);
        end

        // ce held low for 10 cycles mid-calculation
        run_div(1000, 7, 5 + int'($urandom_range(0, 15)), 10, 1'b0, lat);
        chk("ce.lat", lat, 47);
        check_res("ce", 1000, 7);

        // start during busy and in the done cycle must not restart
        run_div(-1000, 7, 0, 0, 1'b1, lat);
        chk("poke.lat", lat, 37);
        check_res("poke", -1000, 7);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        npulse = 0;
        for (int k = 0; k < 45; k++) begin
            if (done || busy) npulse++;
            @(posedge clk); #1;
        end
        chk("poke.extra", npulse, 0);

        // asynchronous reset in the middle of a division
        @(posedge clk); #1;
        din0 = 35'(64'sd5000);
        din1 = 14'd3;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (20) @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        chk("arst.busy", longint'(busy), 0);
        chk("arst.done", longint'(done), 0);
        chk("arst.dout", longint'(dout), 0);
        chk("arst.rem", longint'(rem), 0);
        @(negedge clk);
        reset = 1'b1;
        npulse = 0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            if (done) npulse++;
        end
        chk("arst.nodone", npulse, 0);
        run_div(5000, 3, 0, 0, 1'b0, lat);
        chk("arst.lat", lat, 37);
        check_res("arst", 5000, 3);

        for (int n = 0; n < 1500; n++) begin
            t35 = {$urandom, $urandom};
            a = longint'($signed(t35));
            case ($urandom_range(0, 2))
                0: ;
                1: a = a >>> $urandom_range(12, 34);
                default: a = a >>> $urandom_range(1, 11);
            endcase
            if ($urandom_range(0, 63) == 0) b = 0;
            else if ($urandom_range(0, 3) == 0) b = $urandom_range(1, 15);
            else b = $urandom_range(1, 16383);
            run_div(a, b, 0, 0, 1'b0, lat);
            chk("rnd.lat", lat, 37);
            check_res($sformatf("rnd%0d", n), a, b);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
